// File: rtl/aes_result_drain.sv
// Captures full-width vector stores to the result mailbox, buffers them in a small FIFO
// and streams each block out as VLEN/OUT_W beats over valid/ready.
module aes_result_drain #(
  parameter int          VLEN      = 128,
  parameter int          OUT_W     = 32,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] MBOX_ADDR = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [31:0]      alu_out,
  input  logic [VLEN-1:0]  b,
  input  logic [3:0]       wmem,
  input  logic             vector,
  output logic             m_valid,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             full,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  localparam int NB = VLEN / OUT_W;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [VLEN-1:0]   mem_q [DEPTH];
  logic [0:0]        state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [VLEN-1:0]   shreg_q, shreg_d;
  logic [7:0]        drop_q, drop_d;

  logic empty, cap, hs, last, pop, push, drop;
  logic [NB-1:0][OUT_W-1:0] beats;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cap   = vector && (wmem == 4'hF) && (alu_out == MBOX_ADDR);

  assign m_valid = (state_q == S_SEND);
  assign beats   = shreg_q;
  assign m_data  = m_valid ? beats[beat_q] : '0;
  assign last    = (beat_q == BW'(NB - 1));
  assign m_last  = m_valid && last;
  assign hs      = m_valid && m_ready;

  // Pop only from the registered pointers, so a fresh push is seen one edge later.
  assign pop  = !empty && ((state_q == S_IDLE) || (hs && last));
  assign push = cap && (!full || pop);
  assign drop = cap && !push;

  assign busy     = (state_q == S_SEND) || !empty;
  assign drop_cnt = drop_q;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    shreg_d  = shreg_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    if (pop) begin
      shreg_d  = mem_q[rd_ptr_q[AW-1:0]];
      beat_d   = '0;
      state_d  = S_SEND;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else if (hs) begin
      if (last) begin
        state_d = S_IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
    if (push)                     wr_ptr_d = wr_ptr_q + 1'b1;
    if (drop && drop_q != 8'hFF)  drop_d   = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      shreg_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      shreg_q  <= shreg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= b;
  end

endmodule

// File: tb/tb_aes_result_drain.sv
// Randomized and directed bench for aes_result_drain against a queue-level block model.
module tb_aes_result_drain;

  localparam int          VLEN  = 128;
  localparam int          OUT_W = 32;
  localparam int          DEPTH = 4;
  localparam int          NB    = VLEN / OUT_W;
  localparam logic [31:0] MBOX  = 32'h0000_0100;

  logic             clk = 1'b0;
  logic             clrn;
  logic [31:0]      alu_out;
  logic [VLEN-1:0]  b;
  logic [3:0]       wmem;
  logic             vector;
  logic             m_valid;
  logic [OUT_W-1:0] m_data;
  logic             m_last;
  logic             m_ready;
  logic             full;
  logic             busy;
  logic [7:0]       drop_cnt;

  int checks = 0;
  int errors = 0;

  aes_result_drain #(.VLEN(VLEN), .OUT_W(OUT_W), .DEPTH(DEPTH), .MBOX_ADDR(MBOX)) dut (
    .clk(clk), .clrn(clrn), .alu_out(alu_out), .b(b), .wmem(wmem), .vector(vector),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .full(full), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Model: FIFO of blocks, one block in flight with a beat index, drop counter.
  logic [VLEN-1:0] mq[$];
  logic [VLEN-1:0] cur;
  bit              cur_v;
  int              beat;
  int              drops;
  int              hs_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    cur = '0; cur_v = 0; beat = 0; drops = 0;
  endtask

  task automatic model_edge();
    bit cap, hs, popped, full0;
    cap    = vector && wmem == 4'hF && alu_out == MBOX;
    hs     = cur_v && m_ready;
    full0  = (mq.size() == DEPTH);
    popped = 0;
    if (hs) hs_cnt++;
    if (!cur_v || (hs && beat == NB - 1)) begin
      if (mq.size() > 0) begin
        cur = mq.pop_front(); cur_v = 1; beat = 0; popped = 1;
      end else begin
        cur_v = 0; beat = 0;
      end
    end else if (hs) begin
      beat++;
    end
    if (cap) begin
      if (!full0 || popped) mq.push_back(b);
      else if (drops < 255) drops++;
    end
  endtask

  task automatic compare();
    logic [OUT_W-1:0] ed;
    ed = cur_v ? cur[beat*OUT_W +: OUT_W] : '0;
    chk("m_valid",  m_valid, cur_v);
    chk("m_data",   m_data, ed);
    chk("m_last",   m_last, cur_v && beat == NB - 1);
    chk("full",     full, mq.size() == DEPTH);
    chk("busy",     busy, cur_v || mq.size() > 0);
    chk("drop_cnt", drop_cnt, drops);
  endtask

  // One clock: inputs applied now, model updated at the edge, outputs checked 1ns later.
  task automatic cyc(input logic [31:0] a, input logic [VLEN-1:0] d, input logic [3:0] we,
                     input logic vec, input logic rdy);
    alu_out = a; b = d; wmem = we; vector = vec; m_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle(input logic rdy);
    cyc(32'h0, '0, 4'h0, 1'b0, rdy);
  endtask

  task automatic store(input logic [VLEN-1:0] d, input logic rdy);
    cyc(MBOX, d, 4'hF, 1'b1, rdy);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    #1;
    model_reset();
    compare();
    #7;
    clrn = 1'b1;
  endtask

  function automatic logic [VLEN-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [VLEN-1:0] T1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  initial begin
    clrn = 1'b1; alu_out = '0; b = '0; wmem = '0; vector = 1'b0; m_ready = 1'b0;
    hs_cnt = 0;
    model_reset();
    #2;
    do_reset();

    // 1: single block, ready held high
    store(T1, 1'b1);
    for (int i = 0; i < 7; i++) idle(1'b1);
    chk("t1_busy_after", busy, 1'b0);

    // 2: stalls with ready pattern 1,0,0 repeating
    hs_cnt = 0;
    store(T1, 1'b1);
    for (int i = 0; i < 16; i++) idle((i % 3) == 0);
    chk("t2_handshakes", hs_cnt, NB);

    // 3: six stores with ready low; sixth dropped; then drain
    for (int i = 0; i < 6; i++) store(rnd_blk(), 1'b0);
    chk("t3_full", full, 1'b1);
    chk("t3_drop", drop_cnt, 8'd1);
    hs_cnt = 0;
    for (int i = 0; i < 24; i++) idle(1'b1);
    chk("t3_beats", hs_cnt, 5 * NB);
    chk("t3_idle", busy, 1'b0);

    // 4: ignored accesses
    cyc(MBOX + 32'd16, rnd_blk(), 4'hF, 1'b1, 1'b1);
    cyc(MBOX, rnd_blk(), 4'hF, 1'b0, 1'b1);
    cyc(MBOX, rnd_blk(), 4'b0011, 1'b1, 1'b1);
    cyc(MBOX, rnd_blk(), 4'h0, 1'b1, 1'b1);
    chk("t4_valid", m_valid, 1'b0);
    chk("t4_drop", drop_cnt, 8'd1);

    // 5: full, capture coincides with last-beat handshake
    do_reset();
    for (int i = 0; i < 5; i++) store(rnd_blk(), 1'b0);
    for (int i = 0; i < NB - 1; i++) idle(1'b1);
    store(rnd_blk(), 1'b1);
    chk("t5_full", full, 1'b1);
    chk("t5_drop", drop_cnt, 8'd0);
    for (int i = 0; i < 6 * NB; i++) idle(1'b1);

    // 6: reset mid-block after beat 1 accepted, then clean restart
    store(rnd_blk(), 1'b0);
    idle(1'b1);
    idle(1'b1);
    do_reset();
    chk("t6_valid", m_valid, 1'b0);
    store(T1, 1'b1);
    idle(1'b1);
    chk("t6_beat0", m_data, 32'hCCDDEEFF);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int  r;
      logic rdy;
      r   = $urandom_range(0, 9);
      rdy = ($urandom_range(0, 3) != 0);
      case (r)
        0, 1, 2: store(rnd_blk(), rdy);
        3:       cyc(MBOX, rnd_blk(), 4'($urandom), 1'($urandom), rdy);
        4:       cyc(MBOX ^ 32'(1 << $urandom_range(0, 31)), rnd_blk(), 4'hF, 1'b1, rdy);
        default: idle(rdy);
      endcase
      if (i == 700) do_reset();
    end
    for (int i = 0; i < 40; i++) idle(1'b1);
    chk("end_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
